// File: rtl/pkt_tx_pkg.sv
// Shared types, frame layout constants and the W0 header layout for the transmit framer.
package pkt_tx_pkg;

    localparam int WORD_WIDTH = 16;

    typedef enum logic [1:0] {IDLE, WAIT_CH, SEND, DONE} tx_state_t;

    localparam int         FRAME_LEN = 9;
    localparam logic [3:0] W_HDR     = 4'd0;
    localparam logic [3:0] W_CSUM    = 4'(FRAME_LEN - 1);

    // W0 = {type[2:0], 7'b0, timeslot[5:0]}
    localparam int HDR_TYPE_W   = 3;
    localparam int HDR_TYPE_LSB = WORD_WIDTH - HDR_TYPE_W;
    localparam int HDR_SLOT_W   = 6;
    localparam int HDR_SLOT_LSB = 0;

    typedef struct packed {
        logic [HDR_TYPE_W-1:0] ptype;
        logic [HDR_SLOT_W-1:0] slot;
        logic [WORD_WIDTH-1:0] src;
        logic [WORD_WIDTH-1:0] dst;
        logic [WORD_WIDTH-1:0] hops;
        logic [WORD_WIDTH-1:0] q;
        logic [WORD_WIDTH-1:0] energy;
        logic [WORD_WIDTH-1:0] ch;
        logic [WORD_WIDTH-1:0] hops_ch;
    } fields_t;

    function automatic logic [WORD_WIDTH-1:0] build_hdr(input logic [HDR_TYPE_W-1:0] ptype,
                                                        input logic [HDR_SLOT_W-1:0] slot);
        logic [WORD_WIDTH-1:0] h;
        h = '0;
        h[HDR_TYPE_LSB +: HDR_TYPE_W] = ptype;
        h[HDR_SLOT_LSB +: HDR_SLOT_W] = slot;
        return h;
    endfunction

endpackage

// File: rtl/pkt_tx_framer_if.sv
// Request fields, carrier sense and the outbound word stream between node logic and radio MAC.
interface pkt_tx_framer_if;
    import pkt_tx_pkg::*;

    logic                  tx_setting;
    logic [2:0]            rPacketType;
    logic [5:0]            rTimeslot;
    logic [WORD_WIDTH-1:0] rSourceID;
    logic [WORD_WIDTH-1:0] rDestinationID;
    logic [WORD_WIDTH-1:0] rSourceHops;
    logic [WORD_WIDTH-1:0] rQValue;
    logic [WORD_WIDTH-1:0] rEnergyLeft;
    logic [WORD_WIDTH-1:0] rChosenCH;
    logic [WORD_WIDTH-1:0] rHopsFromCH;
    logic                  channel_clear;
    logic                  tx_ready;
    logic [WORD_WIDTH-1:0] tx_data;
    logic                  tx_valid;
    logic                  tx_sof;
    logic                  tx_eof;
    logic                  tx_busy;
    logic                  tx_done;
    logic                  tx_drop;

    modport master (
        output tx_setting, rPacketType, rTimeslot, rSourceID, rDestinationID, rSourceHops,
               rQValue, rEnergyLeft, rChosenCH, rHopsFromCH, channel_clear, tx_ready,
        input  tx_data, tx_valid, tx_sof, tx_eof, tx_busy, tx_done, tx_drop
    );

    modport slave (
        input  tx_setting, rPacketType, rTimeslot, rSourceID, rDestinationID, rSourceHops,
               rQValue, rEnergyLeft, rChosenCH, rHopsFromCH, channel_clear, tx_ready,
        output tx_data, tx_valid, tx_sof, tx_eof, tx_busy, tx_done, tx_drop
    );

endinterface

// File: rtl/cca_gate.sv
// Clear-channel gate: consecutive channel_clear counter plus a wait-timeout counter.
// Latency: ch_ok / ch_timeout are registered, visible the cycle after the qualifying sample.
// Backpressure: none; counts only while run is high, cleared by a single-cycle clear.
module cca_gate #(
    parameter int CCA_CYCLES  = 8,
    parameter int CCA_TIMEOUT = 255
) (
    input  logic clk,
    input  logic nrst,
    input  logic clear,
    input  logic run,
    input  logic channel_clear,
    output logic ch_ok,
    output logic ch_timeout
);

    localparam int            CW      = $clog2(CCA_CYCLES + 1);
    localparam logic [CW-1:0] CCA_MAX = CW'(CCA_CYCLES);
    localparam logic [7:0]    TO_MAX  = 8'(CCA_TIMEOUT);

    logic [CW-1:0] cca_cnt;
    logic [7:0]    to_cnt;

    always_ff @(posedge clk or posedge nrst) begin
        if (nrst) begin
            cca_cnt <= '0;
            to_cnt  <= '0;
        end else if (clear) begin
            cca_cnt <= '0;
            to_cnt  <= '0;
        end else if (run) begin
            // any busy sample restarts the clear-run; both counters saturate
            if (!channel_clear)
                cca_cnt <= '0;
            else if (cca_cnt < CCA_MAX)
                cca_cnt <= cca_cnt + 1'b1;
            if (to_cnt != 8'hFF)
                to_cnt <= to_cnt + 8'd1;
        end
    end

    assign ch_ok      = (cca_cnt >= CCA_MAX);
    assign ch_timeout = (to_cnt >= TO_MAX);

endmodule

// File: rtl/pkt_tx_framer.sv
// Transmit framer: latches reply fields, waits for a clear channel, streams a 9-word frame with XOR checksum.
// Latency: W0 presented CCA_CYCLES+1 cycles after an accepted request on a continuously clear channel.
// Backpressure: tx_data/tx_valid hold while tx_ready is low; one word per cycle when tx_ready stays high.
module pkt_tx_framer
    import pkt_tx_pkg::*;
#(
    parameter int CCA_CYCLES  = 8,
    parameter int CCA_TIMEOUT = 255
) (
    input logic            clk,
    input logic            nrst,
    pkt_tx_framer_if.slave bus
);

    tx_state_t             state, state_nxt;
    fields_t               fld;
    logic [3:0]            idx;
    logic [WORD_WIDTH-1:0] csum;
    logic [WORD_WIDTH-1:0] word;
    logic                  start;
    logic                  accept;
    logic                  ch_ok;
    logic                  ch_timeout;

    // only the registered IDLE state takes a request, so DONE->IDLE never queues one
    assign start  = (state == IDLE) && bus.tx_setting;
    assign accept = (state == SEND) && bus.tx_ready;

    cca_gate #(
        .CCA_CYCLES  (CCA_CYCLES),
        .CCA_TIMEOUT (CCA_TIMEOUT)
    ) u_cca_gate (
        .clk           (clk),
        .nrst          (nrst),
        .clear         (start),
        .run           (state == WAIT_CH),
        .channel_clear (bus.channel_clear),
        .ch_ok         (ch_ok),
        .ch_timeout    (ch_timeout)
    );

    always_ff @(posedge clk or posedge nrst) begin
        if (nrst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        bus.tx_valid = 1'b0;
        bus.tx_sof   = 1'b0;
        bus.tx_eof   = 1'b0;
        bus.tx_busy  = 1'b1;
        bus.tx_done  = 1'b0;
        bus.tx_drop  = 1'b0;
        case (state)
            IDLE: begin
                bus.tx_busy = 1'b0;
                if (bus.tx_setting)
                    state_nxt = WAIT_CH;
            end
            WAIT_CH: begin
                if (ch_ok) begin
                    state_nxt = SEND;
                end else if (ch_timeout) begin
                    bus.tx_drop = 1'b1;
                    state_nxt   = IDLE;
                end
            end
            SEND: begin
                bus.tx_valid = 1'b1;
                bus.tx_sof   = (idx == W_HDR);
                bus.tx_eof   = (idx == W_CSUM);
                if (accept && idx == W_CSUM)
                    state_nxt = DONE;
            end
            DONE: begin
                bus.tx_done = 1'b1;
                state_nxt   = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge nrst) begin
        if (nrst) begin
            fld  <= '0;
            idx  <= '0;
            csum <= '0;
        end else if (start) begin
            fld.ptype   <= bus.rPacketType;
            fld.slot    <= bus.rTimeslot;
            fld.src     <= bus.rSourceID;
            fld.dst     <= bus.rDestinationID;
            fld.hops    <= bus.rSourceHops;
            fld.q       <= bus.rQValue;
            fld.energy  <= bus.rEnergyLeft;
            fld.ch      <= bus.rChosenCH;
            fld.hops_ch <= bus.rHopsFromCH;
            idx         <= W_HDR;
            csum        <= '0;
        end else if (accept) begin
            // the checksum word is the running XOR; the index parks on it until the next request
            csum <= csum ^ word;
            if (idx != W_CSUM)
                idx <= idx + 4'd1;
        end
    end

    always_comb begin
        word = '0;
        case (idx)
            4'd0:    word = build_hdr(fld.ptype, fld.slot);
            4'd1:    word = fld.src;
            4'd2:    word = fld.dst;
            4'd3:    word = fld.hops;
            4'd4:    word = fld.q;
            4'd5:    word = fld.energy;
            4'd6:    word = fld.ch;
            4'd7:    word = fld.hops_ch;
            4'd8:    word = csum;
            default: word = '0;
        endcase
    end

    assign bus.tx_data = (state == SEND) ? word : '0;

endmodule

// File: tb/tb_pkt_tx_framer.sv
// Scoreboard bench for pkt_tx_framer: frame/CCA reference model feeds queues, a negedge monitor checks.
module tb_pkt_tx_framer;
    import pkt_tx_pkg::*;

    localparam int CCA    = 8;
    localparam int TMO    = 255;
    localparam int CC_LEN = 700;

    logic clk  = 1'b0;
    logic nrst = 1'b1;
    always #5 clk = ~clk;

    pkt_tx_framer_if bus();

    pkt_tx_framer #(
        .CCA_CYCLES  (CCA),
        .CCA_TIMEOUT (TMO)
    ) dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus)
    );

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [15:0] exp_w[$];
    int          exp_ev[$];   // 1 = tx_done expected, 2 = tx_drop expected
    int          pos = 0, hs_total = 0, last_hs_cyc = -10;
    int          w0_cyc = -1, drop_cyc = -1, t0 = 0;
    bit          prev_stall = 1'b0;
    logic [15:0] prev_data;
    int          rdy_mode = 0, stall2 = 0, stall8 = 0;
    bit          cc[CC_LEN];

    task automatic check(input string name, input longint act, input longint exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: event count got 1, required 0", name);
    endtask

    // Edges after the request edge at which W0 (>0) or tx_drop (<0) must first be seen.
    function automatic int cca_outcome();
        int run = 0;
        for (int j = 1; j < CC_LEN; j++) begin
            run = cc[j] ? run + 1 : 0;
            if (run >= CCA) return j + 1;
            if (j >= TMO) return -j;
        end
        return 0;
    endfunction

    task automatic expect_frame(input fields_t f);
        logic [15:0] w;
        logic [15:0] x;
        w = 16'(f.ptype) * 16'd8192 + 16'(f.slot);
        x = w;
        exp_w.push_back(w);
        for (int i = 1; i < 8; i++) begin
            case (i)
                1: w = f.src;
                2: w = f.dst;
                3: w = f.hops;
                4: w = f.q;
                5: w = f.energy;
                6: w = f.ch;
                default: w = f.hops_ch;
            endcase
            x = x ^ w;
            exp_w.push_back(w);
        end
        exp_w.push_back(x);
        exp_ev.push_back(1);
    endtask

    task automatic drive_fields(input fields_t f);
        bus.rPacketType    = f.ptype;
        bus.rTimeslot      = f.slot;
        bus.rSourceID      = f.src;
        bus.rDestinationID = f.dst;
        bus.rSourceHops    = f.hops;
        bus.rQValue        = f.q;
        bus.rEnergyLeft    = f.energy;
        bus.rChosenCH      = f.ch;
        bus.rHopsFromCH    = f.hops_ch;
    endtask

    function automatic fields_t rand_fields();
        fields_t f;
        f.ptype   = 3'($urandom);
        f.slot    = 6'($urandom);
        f.src     = 16'($urandom);
        f.dst     = 16'($urandom);
        f.hops    = 16'($urandom);
        f.q       = 16'($urandom);
        f.energy  = 16'($urandom);
        f.ch      = 16'($urandom);
        f.hops_ch = 16'($urandom);
        return f;
    endfunction

    // Called at posedge+1 with the DUT idle; returns at posedge+1 after the frame has ended.
    task automatic run_frame(input fields_t f);
        int outcome;
        int hs0;
        int j;
        outcome  = cca_outcome();
        hs0      = hs_total;
        w0_cyc   = -1;
        drop_cyc = -1;
        if (outcome > 0) expect_frame(f);
        else             exp_ev.push_back(2);
        drive_fields(f);
        bus.tx_setting = 1'b1;
        @(posedge clk); #1;
        bus.tx_setting = 1'b0;
        t0 = cyc;
        check("busy_after_req", bus.tx_busy, 1);
        j = 1;
        while (exp_ev.size() != 0 && j < CC_LEN) begin
            bus.channel_clear = cc[j];
            j++;
            @(posedge clk); #1;
        end
        if (exp_ev.size() != 0) begin
            fail("frame_timeout");
            exp_w.delete();
            exp_ev.delete();
        end
        if (outcome > 0) begin
            check("w0_latency", w0_cyc - t0, outcome);
            check("handshakes", hs_total - hs0, 9);
        end else begin
            check("drop_latency", drop_cyc - t0, -outcome);
            check("no_valid", w0_cyc, -1);
        end
        check("busy_after_frame", bus.tx_busy, 0);
    endtask

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            1: bus.tx_ready = ($urandom_range(0, 3) != 0);
            2: begin
                if (bus.tx_valid && pos == 2 && stall2 < 3) begin
                    bus.tx_ready = 1'b0;
                    stall2++;
                end else if (bus.tx_valid && pos == 8 && stall8 < 1) begin
                    bus.tx_ready = 1'b0;
                    stall8++;
                end else begin
                    bus.tx_ready = 1'b1;
                end
            end
            default: bus.tx_ready = 1'b1;
        endcase
    end

    always @(negedge clk) begin : monitor
        logic [15:0] w;
        int ev;
        if (!nrst) begin
            if (bus.tx_valid) begin
                if (prev_stall) check("hold_data", bus.tx_data, prev_data);
                if (pos == 0 && w0_cyc < 0) w0_cyc = cyc;
                if (bus.tx_ready) begin
                    if (exp_w.size() == 0) begin
                        fail("unexpected_word");
                    end else begin
                        w = exp_w.pop_front();
                        check("word", bus.tx_data, w);
                    end
                    check("sof", bus.tx_sof, pos == 0);
                    check("eof", bus.tx_eof, pos == 8);
                    pos = (pos == 8) ? 0 : pos + 1;
                    hs_total++;
                    last_hs_cyc = cyc;
                end
                prev_stall = !bus.tx_ready;
                prev_data  = bus.tx_data;
            end else begin
                if (prev_stall) check("valid_held", bus.tx_valid, 1);
                prev_stall = 1'b0;
            end
            if (bus.tx_done) begin
                if (exp_ev.size() == 0) fail("unexpected_done");
                else begin
                    ev = exp_ev.pop_front();
                    check("done_event", 1, ev);
                    check("done_timing", cyc, last_hs_cyc + 1);
                end
            end
            if (bus.tx_drop) begin
                if (exp_ev.size() == 0) fail("unexpected_drop");
                else begin
                    ev = exp_ev.pop_front();
                    check("drop_event", 2, ev);
                    drop_cyc = cyc;
                end
            end
        end
    end

    task automatic check_outputs_zero(input string tag);
        check({tag, "_valid"}, bus.tx_valid, 0);
        check({tag, "_data"},  bus.tx_data,  0);
        check({tag, "_sof"},   bus.tx_sof,   0);
        check({tag, "_eof"},   bus.tx_eof,   0);
        check({tag, "_busy"},  bus.tx_busy,  0);
        check({tag, "_done"},  bus.tx_done,  0);
        check({tag, "_drop"},  bus.tx_drop,  0);
    endtask

    task automatic fill_cc(input int kind);
        for (int i = 0; i < CC_LEN; i++) begin
            case (kind)
                0:       cc[i] = 1'b1;
                3:       cc[i] = ($urandom_range(0, 15) == 0);
                default: cc[i] = ($urandom_range(0, 7) != 0);
            endcase
        end
    endtask

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation time limit reached, required frame completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        fields_t f;
        int      hs_before;
        bus.tx_setting    = 1'b0;
        bus.channel_clear = 1'b0;
        drive_fields('0);
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        nrst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_outputs_zero("idle");

        // basic frame
        f = '{ptype: 3'd2, slot: 6'd5, src: 16'h0011, dst: 16'h0001, hops: 16'h0003,
              q: 16'h1234, energy: 16'h0F00, ch: 16'h0007, hops_ch: 16'h0002};
        fill_cc(0);
        run_frame(f);
        check("basic_w0_latency", w0_cyc - t0, CCA + 1);

        // backpressure at W2 and W8
        rdy_mode = 2; stall2 = 0; stall8 = 0;
        run_frame(rand_fields());
        rdy_mode = 0;

        // CCA restart: 5 clear, 1 busy, then clear
        fill_cc(0);
        cc[6] = 1'b0;
        run_frame(rand_fields());
        check("cca_restart_w0", w0_cyc - t0, 6 + CCA + 1);

        // timeout
        for (int i = 0; i < CC_LEN; i++) cc[i] = 1'b0;
        run_frame(rand_fields());
        check("timeout_drop", drop_cyc - t0, TMO);

        // request while busy must be ignored
        fill_cc(0);
        hs_before = hs_total;
        fork
            run_frame(f);
            begin
                for (int k = 0; k < 200 && pos < 1; k++) @(posedge clk);
                #1;
                bus.tx_setting = 1'b1;
                bus.rSourceID  = 16'hBEEF;
                @(posedge clk); #1;
                bus.tx_setting = 1'b0;
            end
        join
        repeat (40) @(posedge clk);
        #1;
        check("busy_req_no_second", hs_total - hs_before, 9);
        check("busy_req_idle", bus.tx_busy, 0);

        // reset in the middle of SEND, at W4
        f = rand_fields();
        expect_frame(f);
        drive_fields(f);
        bus.channel_clear = 1'b1;
        bus.tx_setting    = 1'b1;
        @(posedge clk); #1;
        bus.tx_setting = 1'b0;
        for (int k = 0; k < 100 && pos != 4; k++) @(negedge clk);
        check("reached_w4", pos, 4);
        @(posedge clk); #2;
        nrst = 1'b1;
        #1;
        check_outputs_zero("async_rst");
        exp_w.delete();
        exp_ev.delete();
        pos = 0;
        prev_stall = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        nrst = 1'b0;
        @(posedge clk); #1;
        run_frame(rand_fields());

        // randomized frames, random ready and carrier sense
        rdy_mode = 1;
        for (int n = 0; n < 20; n++) begin
            fill_cc($urandom_range(0, 3));
            run_frame(rand_fields());
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end
        rdy_mode = 0;
        repeat (5) @(posedge clk);
        #1;
        check("final_queue_empty", exp_w.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
